// File: rtl/dma_ctrl.sv
// dma_ctrl: memory-to-memory DMA controller for the 6801 system bus.
//
// The CPU programs SRC, DST and CNT through an 8-byte register window and then
// writes CTRL.start.  The block requests the bus.  Once it is granted, it copies
// one byte per RD/WR cycle pair as bus master.  It gives the bus back for one
// cycle after every BURST copies.  done (and irq when ie is set) flags
// completion.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   AD, DI, DO        register select, CPU write data, combinational read data
//   rw, cs            CPU direction (1 = read) and vma-qualified register select
//   irq               level interrupt, done & ie
//   bus_req/bus_grant bus mastership handshake
//   m_AD, m_DO, m_DI  master address, write data, read data
//   m_rw, m_vma       master direction (1 = read) and cycle valid
//
// Bus handshake: bus_req is a request that stays high from REQ through every
// RD/WR pair of a burst.  A master cycle is issued only after bus_grant has
// been seen high.  The top level keeps bus_grant stable while bus_req is high.
// Grant is sampled only in REQ and at the end of each WR.
module dma_ctrl #(
    parameter int BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  AD,
    input  logic [7:0]  DI,
    output logic [7:0]  DO,
    input  logic        rw,
    input  logic        cs,
    output logic        irq,
    output logic        bus_req,
    input  logic        bus_grant,
    output logic [15:0] m_AD,
    output logic [7:0]  m_DO,
    input  logic [7:0]  m_DI,
    output logic        m_rw,
    output logic        m_vma
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_RD, S_WR, S_REL, S_DONE, S_DONE_ABORT
    } state_t;

    localparam logic [7:0] BURST_LD = 8'(BURST);

    state_t      state, state_next;
    logic [15:0] src, dst, cnt;
    logic [7:0]  burst_cnt, latch;
    logic        ie, src_fixed, dst_fixed, done, aborted, abort_pend;
    logic        busy, wr_en, start_req;

    assign busy      = (state != S_IDLE);
    assign wr_en     = cs && !rw;
    assign start_req = wr_en && (AD == 3'd6) && DI[0] && !busy;
    assign irq       = done & ie;

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:       if (start_req && cnt != 16'd0) state_next = S_REQ;
            S_REQ: begin
                if (abort_pend)     state_next = S_DONE_ABORT;
                else if (bus_grant) state_next = S_RD;
            end
            S_RD:         state_next = S_WR;
            S_WR: begin
                if (cnt == 16'd1)           state_next = S_DONE;
                else if (abort_pend)        state_next = S_DONE_ABORT;
                else if (burst_cnt == 8'd1) state_next = S_REL;
                else if (bus_grant)         state_next = S_RD;
                else                        state_next = S_REQ;
            end
            S_REL:        state_next = S_REQ;
            S_DONE:       state_next = S_IDLE;
            S_DONE_ABORT: state_next = S_IDLE;
            default:      state_next = S_IDLE;
        endcase
    end

    // Master port outputs, decoded from state
    always_comb begin
        bus_req = (state == S_REQ) || (state == S_RD) || (state == S_WR);
        m_vma   = (state == S_RD) || (state == S_WR);
        m_rw    = (state != S_WR);
        m_AD    = 16'h0000;
        m_DO    = 8'h00;
        if (state == S_RD) m_AD = src;
        if (state == S_WR) begin
            m_AD = dst;
            m_DO = latch;
        end
    end

    // CPU read mux
    always_comb begin
        DO = 8'h00;
        case (AD)
            3'd0: DO = src[15:8];
            3'd1: DO = src[7:0];
            3'd2: DO = dst[15:8];
            3'd3: DO = dst[7:0];
            3'd4: DO = cnt[15:8];
            3'd5: DO = cnt[7:0];
            3'd6: DO = {done, aborted, 2'b00, dst_fixed, src_fixed, ie, busy};
            3'd7: DO = {done, aborted, 6'b000000};
            default: DO = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            src        <= 16'h0000;
            dst        <= 16'h0000;
            cnt        <= 16'h0000;
            burst_cnt  <= 8'h00;
            latch      <= 8'h00;
            ie         <= 1'b0;
            src_fixed  <= 1'b0;
            dst_fixed  <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            state <= state_next;

            // CPU writes; address/count registers are frozen while busy
            if (wr_en) begin
                case (AD)
                    3'd0: if (!busy) src[15:8] <= DI;
                    3'd1: if (!busy) src[7:0]  <= DI;
                    3'd2: if (!busy) dst[15:8] <= DI;
                    3'd3: if (!busy) dst[7:0]  <= DI;
                    3'd4: if (!busy) cnt[15:8] <= DI;
                    3'd5: if (!busy) cnt[7:0]  <= DI;
                    3'd6: begin
                        ie <= DI[1];
                        if (!busy) begin
                            src_fixed <= DI[2];
                            dst_fixed <= DI[3];
                        end else if (DI[4]) begin
                            abort_pend <= 1'b1;
                        end
                    end
                    3'd7: begin
                        done    <= 1'b0;
                        aborted <= 1'b0;
                    end
                    default: ;
                endcase
            end

            // Transfer bookkeeping; placed after the CPU writes so that a
            // completion in the same cycle as a STAT write leaves done set.
            case (state)
                S_IDLE: begin
                    abort_pend <= 1'b0;
                    if (start_req) begin
                        if (cnt == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            done      <= 1'b0;
                            aborted   <= 1'b0;
                            burst_cnt <= BURST_LD;
                        end
                    end
                end
                S_RD:  latch <= m_DI;
                S_WR: begin
                    if (!src_fixed) src <= src + 16'd1;
                    if (!dst_fixed) dst <= dst + 16'd1;
                    cnt       <= cnt - 16'd1;
                    burst_cnt <= burst_cnt - 8'd1;
                end
                S_REL: burst_cnt <= BURST_LD;
                default: ;
            endcase

            if (state_next == S_DONE)       done    <= 1'b1;
            if (state_next == S_DONE_ABORT) aborted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dma_ctrl.sv
// tb_dma_ctrl: directed bench for dma_ctrl with a byte-wide SRAM model on the
// master port and a grant generator.  The grant is either held high or follows
// bus_req after two cycles.
module tb_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  AD;
    logic [7:0]  DI;
    logic [7:0]  DO;
    logic        rw, cs;
    logic        irq, bus_req, bus_grant;
    logic [15:0] m_AD;
    logic [7:0]  m_DO, m_DI;
    logic        m_rw, m_vma;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] rd_q[$];
    logic [15:0] wr_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  wr_data_q[$];
    int          req_hi, low_pend, low_total;
    logic        seen_req;
    logic        grant_always;
    int          req_cycles;

    dma_ctrl #(.BURST(4)) dut (
        .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
        .irq(irq), .bus_req(bus_req), .bus_grant(bus_grant),
        .m_AD(m_AD), .m_DO(m_DO), .m_DI(m_DI), .m_rw(m_rw), .m_vma(m_vma)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Grant generator: stable while bus_req is high
    always @(posedge clk) begin
        if (bus_req) req_cycles <= req_cycles + 1;
        else         req_cycles <= 0;
    end
    assign bus_grant = grant_always | (bus_req && req_cycles >= 2);

    // SRAM model and bus monitor, sampled mid-cycle
    assign m_DI = mem[m_AD];
    always @(negedge clk) begin
        if (m_vma && m_rw) rd_q.push_back(m_AD);
        if (m_vma && !m_rw) begin
            wr_q.push_back(m_AD);
            wr_data_q.push_back(m_DO);
            mem[m_AD] = m_DO;
        end
        if (bus_req) begin
            req_hi++;
            if (seen_req) low_total += low_pend;
            low_pend = 0;
            seen_req = 1'b1;
        end else if (seen_req) begin
            low_pend++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        AD = a; DI = d; rw = 1'b0; cs = 1'b1;
        @(negedge clk);
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b0; rw = 1'b1; AD = a;
        #1 d = DO;
    endtask

    task automatic set_xfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
        wr_reg(3'd0, s[15:8]); wr_reg(3'd1, s[7:0]);
        wr_reg(3'd2, d[15:8]); wr_reg(3'd3, d[7:0]);
        wr_reg(3'd4, n[15:8]); wr_reg(3'd5, n[7:0]);
    endtask

    task automatic clear_mon();
        rd_q.delete(); wr_q.delete(); wr_data_q.delete(); exp_q.delete();
        req_hi = 0; low_pend = 0; low_total = 0; seen_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            cs = 1'b0; rw = 1'b1; AD = 3'd6;
            #1 n++;
        end while (DO[0] && n < budget);
        check("idle_timeout", {31'd0, DO[0]}, 32'd0);
    endtask

    task automatic check_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] v;
        rd_reg(a, v);
        check(tag, {24'd0, v}, {24'd0, exp});
    endtask

    initial begin
        logic [7:0] v;
        int n;
        int wr_before;
        rst = 1'b1; AD = 3'd0; DI = 8'h00; rw = 1'b1; cs = 1'b0;
        grant_always = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        @(negedge clk); #1;
        check("rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("rst_m_vma",   {31'd0, m_vma},   32'd0);
        check("rst_m_rw",    {31'd0, m_rw},    32'd1);
        check("rst_m_AD",    {16'd0, m_AD},    32'd0);
        check("rst_m_DO",    {24'd0, m_DO},    32'd0);
        check("rst_irq",     {31'd0, irq},     32'd0);
        for (int i = 0; i < 8; i++) check_reg("rst_reg", 3'(i), 8'h00);

        // Register readback
        set_xfer(16'h1234, 16'h5678, 16'h0003);
        check_reg("rb_src_h", 3'd0, 8'h12);
        check_reg("rb_src_l", 3'd1, 8'h34);
        check_reg("rb_dst_h", 3'd2, 8'h56);
        check_reg("rb_dst_l", 3'd3, 8'h78);
        check_reg("rb_cnt_h", 3'd4, 8'h00);
        check_reg("rb_cnt_l", 3'd5, 8'h03);
        check_reg("rb_ctrl",  3'd6, 8'h00);
        check("rb_bus_req", {31'd0, bus_req}, 32'd0);

        // Three-byte copy, grant two cycles after request
        mem[16'h2000] = 8'hAA; mem[16'h2001] = 8'hBB; mem[16'h2002] = 8'hCC;
        set_xfer(16'h2000, 16'h3000, 16'h0003);
        clear_mon();
        exp_q.push_back(8'hAA); exp_q.push_back(8'hBB); exp_q.push_back(8'hCC);
        wr_reg(3'd6, 8'h03);
        wait_idle(200);
        check("cp_rd_pairs", rd_q.size(), 3);
        check("cp_wr_pairs", wr_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < wr_data_q.size() && exp_q.size() > 0) begin
                check("cp_wr_addr", {16'd0, wr_q[i]}, 32'h3000 + i);
                check("cp_wr_data", {24'd0, wr_data_q[i]}, {24'd0, exp_q.pop_front()});
            end
        end
        check("cp_mem_3002", {24'd0, mem[16'h3002]}, 32'hCC);
        check_reg("cp_src_h", 3'd0, 8'h20);
        check_reg("cp_src_l", 3'd1, 8'h03);
        check_reg("cp_dst_l", 3'd3, 8'h03);
        check_reg("cp_cnt_l", 3'd5, 8'h00);
        check_reg("cp_stat",  3'd7, 8'h80);
        check_reg("cp_ctrl",  3'd6, 8'h82);
        check("cp_irq", {31'd0, irq}, 32'd1);
        wr_reg(3'd7, 8'h00);
        #1 check("cp_irq_clr", {31'd0, irq}, 32'd0);

        // Zero count: done immediately, no bus request
        set_xfer(16'h0100, 16'h0200, 16'h0000);
        clear_mon();
        wr_reg(3'd6, 8'h03);
        #1;
        check("z_irq", {31'd0, irq}, 32'd1);
        check("z_bus_req", {31'd0, bus_req}, 32'd0);
        repeat (5) @(negedge clk);
        check("z_req_cycles", req_hi, 0);
        check_reg("z_stat", 3'd7, 8'h80);
        wr_reg(3'd7, 8'h00);

        // Burst release with grant always high
        grant_always = 1'b1;
        set_xfer(16'h4000, 16'h5000, 16'h0006);
        clear_mon();
        wr_reg(3'd6, 8'h03);
        wait_idle(200);
        check("b_wr_pairs", wr_q.size(), 6);
        check("b_req_low", low_total, 1);
        check("b_req_hi", req_hi, 2 * 6 + 2);
        check_reg("b_stat", 3'd7, 8'h80);

        // Source wrap, fixed destination
        mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22;
        set_xfer(16'hFFFF, 16'hE600, 16'h0002);
        clear_mon();
        wr_reg(3'd6, 8'h0B);
        wait_idle(200);
        check("w_rd_n", rd_q.size(), 2);
        check("w_wr_n", wr_q.size(), 2);
        if (rd_q.size() == 2 && wr_q.size() == 2) begin
            check("w_rd0", {16'd0, rd_q[0]}, 32'hFFFF);
            check("w_rd1", {16'd0, rd_q[1]}, 32'h0000);
            check("w_wr0", {16'd0, wr_q[0]}, 32'hE600);
            check("w_wr1", {16'd0, wr_q[1]}, 32'hE600);
        end
        check("w_mem", {24'd0, mem[16'hE600]}, 32'h22);
        check_reg("w_src_l", 3'd1, 8'h01);
        check_reg("w_dst_l", 3'd3, 8'h00);

        // Abort after the second write
        set_xfer(16'h6000, 16'h7000, 16'd10);
        clear_mon();
        wr_reg(3'd6, 8'h03);
        n = 0;
        while (wr_q.size() < 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("a_wait", {31'd0, wr_q.size() >= 2}, 32'd1);
        wr_reg(3'd6, 8'h12);
        wait_idle(200);
        check("a_wr_pairs", wr_q.size(), 3);
        check_reg("a_cnt_l", 3'd5, 8'h07);
        check_reg("a_stat",  3'd7, 8'h40);
        check_reg("a_ctrl",  3'd6, 8'h42);
        check("a_irq", {31'd0, irq}, 32'd0);

        // Reset during a read cycle
        set_xfer(16'h8000, 16'h9000, 16'd5);
        clear_mon();
        wr_reg(3'd6, 8'h03);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_vma && m_rw) && n < 100);
        check("r_saw_rd", {31'd0, m_vma && m_rw}, 32'd1);
        wr_before = wr_q.size();
        rst = 1'b1;
        @(negedge clk); #1;
        check("r_bus_req", {31'd0, bus_req}, 32'd0);
        check("r_m_vma", {31'd0, m_vma}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("r_no_wr", wr_q.size(), wr_before);
        check_reg("r_src_h", 3'd0, 8'h00);
        check_reg("r_cnt_l", 3'd5, 8'h00);
        check_reg("r_ctrl",  3'd6, 8'h00);
        rd_reg(3'd7, v);
        check("r_stat", {24'd0, v}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
